axi_cmd_queue: RTL and testbench

Command queue and issue sequencer sitting directly upstream of the AXI4-Lite master's control interface (start/write/addr/wdata/wstrb, busy/done/rdata/resp). It buffers up to DEPTH read/write requests from a valid/ready producer. It issues them one at a time to the master as single-cycle start pulses, and returns each completion (rdata, resp) on a valid/ready response port. A watchdog converts a hung transaction into an SLVERR response.

---
 rtl/axi_cmd_queue.sv | 207 ++++++++++++++++++++
 tb/tb_axi_cmd_queue.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_queue.sv
// Command queue and issue sequencer in front of an AXI4-Lite master control port.
// Buffers DEPTH requests and issues them one at a time as single-cycle start pulses.
// Each completion is returned in command order on a valid/ready response port.
// A watchdog turns a transaction that never completes into a forced SLVERR response.
module axi_cmd_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    input  logic [3:0]             cmd_wstrb,
    output logic [$clog2(DEPTH):0] cmd_count,
    output logic                   m_start,
    output logic                   m_write,
    output logic [ADDR_WIDTH-1:0]  m_addr,
    output logic [DATA_WIDTH-1:0]  m_wdata,
    output logic [3:0]             m_wstrb,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic [DATA_WIDTH-1:0]  m_rdata,
    input  logic [1:0]             m_resp,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic                   rsp_timeout
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WD_W   = $clog2(TIMEOUT);
    localparam int unsigned STRB_W = 4;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     wstrb;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RSP   = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    cmd_t             cmd_in;
    cmd_t             head;

    // Sequencer state and registered outputs with their next values
    state_t                state;
    state_t                state_nxt;
    cmd_t                  m_req;
    cmd_t                  m_req_nxt;
    logic                  m_start_nxt;
    logic [WD_W-1:0]       wd;
    logic [WD_W-1:0]       wd_nxt;
    logic                  rsp_valid_nxt;
    logic                  rsp_write_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
    logic [1:0]            rsp_resp_nxt;
    logic                  rsp_timeout_nxt;

    assign cmd_ready = (count != CNT_W'(DEPTH));
    assign cmd_count = count;
    assign push      = cmd_valid && cmd_ready;

    assign cmd_in.write = cmd_write;
    assign cmd_in.addr  = cmd_addr;
    assign cmd_in.wdata = cmd_wdata;
    assign cmd_in.wstrb = cmd_wstrb;
    assign head         = mem[rd_ptr];

    assign m_write = m_req.write;
    assign m_addr  = m_req.addr;
    assign m_wdata = m_req.wdata;
    assign m_wstrb = m_req.wstrb;

    // Command storage; contents need no reset because count gates every read
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    // Circular pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Next-state, issue and completion capture
    always_comb begin
        state_nxt       = state;
        pop             = 1'b0;
        m_start_nxt     = 1'b0;
        m_req_nxt       = m_req;
        wd_nxt          = wd;
        rsp_valid_nxt   = rsp_valid;
        rsp_write_nxt   = rsp_write;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_resp_nxt    = rsp_resp;
        rsp_timeout_nxt = rsp_timeout;

        case (state)
            IDLE: begin
                // m_busy also covers a master still recovering from a timed-out request
                if ((count != '0) && !m_busy) begin
                    m_req_nxt   = head;
                    m_start_nxt = 1'b1;
                    state_nxt   = START;
                end
            end
            START: begin
                pop       = 1'b1;
                wd_nxt    = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    rsp_valid_nxt   = 1'b1;
                    rsp_write_nxt   = m_req.write;
                    rsp_rdata_nxt   = m_req.write ? '0 : m_rdata;
                    rsp_resp_nxt    = m_resp;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = RSP;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    rsp_valid_nxt   = 1'b1;
                    rsp_write_nxt   = m_req.write;
                    rsp_rdata_nxt   = '0;
                    rsp_resp_nxt    = RESP_SLVERR;
                    rsp_timeout_nxt = 1'b1;
                    state_nxt       = RSP;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= IDLE;
            m_start     <= 1'b0;
            m_req       <= '0;
            wd          <= '0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            m_start     <= m_start_nxt;
            m_req       <= m_req_nxt;
            wd          <= wd_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_write   <= rsp_write_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_resp    <= rsp_resp_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_axi_cmd_queue.sv
// Self-checking bench for axi_cmd_queue: command table plus hand-written corner sequences.
// A small master model and a response scoreboard provide every expected value.
`timescale 1ns/1ps
module tb_axi_cmd_queue;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned NVEC    = 5;

    logic          ACLK    = 1'b0;
    logic          ARESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic [2:0]    cmd_count;
    logic          m_start;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_busy  = 1'b0;
    logic          m_done  = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_resp  = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;

    axi_cmd_queue #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .cmd_count  (cmd_count),
        .m_start    (m_start),
        .m_write    (m_write),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_busy     (m_busy),
        .m_done     (m_done),
        .m_rdata    (m_rdata),
        .m_resp     (m_resp),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .rsp_timeout(rsp_timeout)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic          write;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic          timeout;
    } rsp_t;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
    } iss_t;

    typedef struct {
        int            lat;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } mst_t;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        int            lat;
        logic [DW-1:0] m_rdata;
        logic [1:0]    m_resp;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp;
    } vec_t;

    rsp_t exp_q[$];
    iss_t iss_q[$];
    mst_t mst_q[$];
    vec_t vecs[NVEC];

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   starts     = 0;
    int   last_start = 0;
    int   last_rise  = 0;
    logic force_busy = 1'b0;
    logic hang       = 1'b0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual bound expired, required event within bound", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic rsp_t mk_exp(input logic w, input logic [DW-1:0] mr, input logic [1:0] r);
        rsp_t e;
        e.write   = w;
        e.rdata   = w ? '0 : mr;
        e.resp    = r;
        e.timeout = 1'b0;
        return e;
    endfunction

    // Master model: answers each start pulse after lat idle WAIT cycles; hang withholds done
    task automatic run_master();
        mst_t t;
        int   cnt  = 0;
        logic pend = 1'b0;
        logic [DW-1:0] cur_rdata = '0;
        logic [1:0]    cur_resp  = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                m_done = 1'b0;
                pend   = 1'b0;
                m_busy = force_busy;
            end else begin
                m_done = 1'b0;
                if (pend && !hang) begin
                    if (cnt == 0) begin
                        m_done  = 1'b1;
                        m_rdata = cur_rdata;
                        m_resp  = cur_resp;
                        pend    = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (m_start) begin
                    if (mst_q.size() > 0) t = mst_q.pop_front();
                    else t = '{0, 32'h0, 2'b00};
                    pend      = 1'b1;
                    cnt       = t.lat;
                    cur_rdata = t.rdata;
                    cur_resp  = t.resp;
                end
                m_busy = force_busy || pend;
            end
        end
    endtask

    // Monitor: checks issued requests and scoreboards completions on handshake
    task automatic run_monitor();
        rsp_t e;
        iss_t c;
        logic rv_q = 1'b0;
        logic ms_q = 1'b0;
        int   prev_start = -100;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                rv_q       = 1'b0;
                ms_q       = 1'b0;
                prev_start = -100;
            end else begin
                if (rsp_valid && !rv_q) last_rise = cyc;
                rv_q = rsp_valid;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("rsp_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_write",   64'(rsp_write),   64'(e.write));
                        check("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
                        check("rsp_resp",    64'(rsp_resp),    64'(e.resp));
                        check("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
                    end
                end
                if (m_start) begin
                    starts++;
                    check("m_start_width", 64'(ms_q), 64'(0));
                    check("m_start_gap_ge4", 64'((cyc - prev_start) >= 4), 64'(1));
                    prev_start = cyc;
                    last_start = cyc;
                    if (iss_q.size() == 0) begin
                        fail_now("m_start_unexpected");
                    end else begin
                        c = iss_q.pop_front();
                        check("m_addr",  64'(m_addr),  64'(c.addr));
                        check("m_wdata", 64'(m_wdata), 64'(c.wdata));
                        check("m_ctl",   64'({m_write, m_wstrb}), 64'({c.write, c.wstrb}));
                    end
                end
                ms_q = m_start;
            end
        end
    endtask

    // Presents one command; caller is just after a rising edge
    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] s, input int lat, input logic [DW-1:0] mr,
                        input logic [1:0] mresp, input rsp_t e);
        mst_t m;
        int   n    = 0;
        bit   done = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        while (!done && n < 50) begin
            @(negedge ACLK);
            if (cmd_ready) begin
                iss_q.push_back('{w, a, d, s});
                m.lat   = lat;
                m.rdata = mr;
                m.resp  = mresp;
                mst_q.push_back(m);
                exp_q.push_back(e);
                done = 1'b1;
            end
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        if (!done) fail_now("push_accept");
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge ACLK);
            n++;
        end
        if (exp_q.size() != 0) fail_now(name);
        tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_cmd_count"}, 64'(cmd_count), 64'(0));
        check({tag, "_m_start"},   64'(m_start),   64'(0));
        check({tag, "_m_ctl"},     64'({m_write, m_wstrb}), 64'(0));
        check({tag, "_m_addr"},    64'(m_addr),    64'(0));
        check({tag, "_m_wdata"},   64'(m_wdata),   64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_flags"}, 64'({rsp_write, rsp_resp, rsp_timeout}), 64'(0));
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual simulation still running, required finish");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        logic [DW+4:0] cap;
        int            s0;
        int            bad;
        int            n;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 0, 32'h1111_2222, 2'b00, 32'h0000_0000, 2'b00};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 1, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'b00};
        vecs[2] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 4'h0, 3, 32'h0BAD_F00D, 2'b10, 32'h0BAD_F00D, 2'b10};
        vecs[3] = '{1'b1, 32'h0000_003C, 32'h1234_5678, 4'h3, 2, 32'h7777_7777, 2'b11, 32'h0000_0000, 2'b11};
        vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 6, 32'h8000_0001, 2'b01, 32'h8000_0001, 2'b01};

        fork
            run_master();
            run_monitor();
        join_none

        // Reset values while asserted and just after release
        repeat (2) @(negedge ACLK);
        check_reset("rst_hold");
        tick();
        ARESETn = 1'b1;
        @(negedge ACLK);
        check_reset("rst_rel");
        tick();

        // Table: single transactions; completion latency is fixed by the master delay
        for (int i = 0; i < int'(NVEC); i++) begin
            push(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].lat,
                 vecs[i].m_rdata, vecs[i].m_resp,
                 '{vecs[i].write, vecs[i].exp_rdata, vecs[i].exp_resp, 1'b0});
            wait_drain(60, "drain_vec");
            check("vec_latency", 64'(last_rise - last_start), 64'(vecs[i].lat + 2));
        end

        // Watchdog: forced SLVERR TIMEOUT cycles after WAIT entry; late done ignored
        hang = 1'b1;
        push(1'b1, 32'h0000_0040, 32'hCAFE_0040, 4'hF, 0, 32'h0, 2'b00, '{1'b1, 32'h0, 2'b10, 1'b1});
        wait_drain(40, "drain_timeout");
        check("timeout_latency", 64'(last_rise - last_start), 64'(TIMEOUT + 1));
        push(1'b0, 32'h0000_0044, 32'h0, 4'h0, 1, 32'h4444_0044, 2'b01, mk_exp(1'b0, 32'h4444_0044, 2'b01));
        s0 = starts;
        repeat (5) tick();
        @(negedge ACLK);
        check("no_issue_while_busy", 64'(starts), 64'(s0));
        tick();
        hang = 1'b0;
        wait_drain(40, "drain_after_timeout");
        check("issue_after_recover", 64'(starts), 64'(s0 + 1));

        // Response backpressure: rsp_* frozen and nothing issued until the handshake
        rsp_ready = 1'b0;
        push(1'b0, 32'h0000_0050, 32'h0, 4'h0, 0, 32'h5050_A0A0, 2'b00, mk_exp(1'b0, 32'h5050_A0A0, 2'b00));
        push(1'b1, 32'h0000_0054, 32'h5454_5454, 4'h1, 0, 32'h9999_9999, 2'b00, mk_exp(1'b1, 32'h9999_9999, 2'b00));
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!rsp_valid) fail_now("bp_rsp_valid");
        cap = {rsp_write, rsp_rdata, rsp_resp, rsp_timeout};
        s0  = starts;
        bad = 0;
        repeat (10) begin
            @(negedge ACLK);
            if ({rsp_write, rsp_rdata, rsp_resp, rsp_timeout} !== cap || rsp_valid !== 1'b1) bad++;
        end
        check("bp_unstable_cycles", 64'(bad), 64'(0));
        check("bp_no_issue", 64'(starts), 64'(s0));
        tick();
        rsp_ready = 1'b1;
        wait_drain(60, "drain_bp");

        // Fill with the master stalled: fifth command waits for space, all drain in order
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(1'(i % 2), 32'h0000_0100 + 32'(i * 4), 32'h0F0F_0000 + 32'(i), 4'hF, 1,
                 32'hB0B0_0000 + 32'(i), 2'b00, mk_exp(1'(i % 2), 32'hB0B0_0000 + 32'(i), 2'b00));
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0110;
        @(negedge ACLK);
        check("full_cmd_ready", 64'(cmd_ready), 64'(0));
        check("full_cmd_count", 64'(cmd_count), 64'(4));
        s0 = starts;
        tick();
        @(negedge ACLK);
        check("full_count_hold", 64'(cmd_count), 64'(4));
        check("full_no_issue", 64'(starts), 64'(s0));
        tick();
        force_busy = 1'b0;
        push(1'b0, 32'h0000_0110, 32'h0, 4'h0, 1, 32'hB0B0_0004, 2'b00, mk_exp(1'b0, 32'hB0B0_0004, 2'b00));
        wait_drain(200, "drain_fill");
        @(negedge ACLK);
        check("fill_count_empty", 64'(cmd_count), 64'(0));
        check("fill_ready_empty", 64'(cmd_ready), 64'(1));
        tick();

        // Reset while one request is in WAIT and three are queued
        hang = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 32'h0000_0200 + 32'(i * 4), 32'h2222_0000 + 32'(i), 4'hF, 0,
                 32'h0, 2'b00, mk_exp(1'b1, 32'h0, 2'b00));
        end
        @(negedge ACLK);
        check("pre_reset_count", 64'(cmd_count), 64'(3));
        check("pre_reset_in_wait", 64'(rsp_valid), 64'(0));
        tick();
        ARESETn = 1'b0;
        exp_q.delete();
        iss_q.delete();
        mst_q.delete();
        hang = 1'b0;
        @(negedge ACLK);
        check_reset("rst_mid");
        tick();
        ARESETn = 1'b1;
        s0  = starts;
        bad = 0;
        repeat (8) begin
            @(negedge ACLK);
            if (rsp_valid !== 1'b0 || cmd_count !== 3'd0) bad++;
        end
        check("post_reset_quiet", 64'(bad), 64'(0));
        check("post_reset_no_start", 64'(starts), 64'(s0));
        tick();
        push(1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 32'h3003_3003, 2'b00, mk_exp(1'b0, 32'h3003_3003, 2'b00));
        wait_drain(40, "drain_post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
